// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bus between the core MEM stage (master) and
// the data memory load/store unit (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. While req_valid is high and req_ready is low, the
// request is not taken. The slave does not queue requests, so a request held
// while the slave is busy is ignored until req_ready rises again.
// rsp_valid is a one-cycle pulse that has no ready. rsp_rdata and rsp_err are
// meaningful only while rsp_valid is high.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  slave can accept (idle)
//   req_we     master->slave  1 = store, 0 = load
//   req_funct3 master->slave  RV32I access size/sign code
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  right-aligned store data
//   req_pc     master->slave  PC of the issuing instruction (trace only)
//   rsp_valid  slave->master  access complete pulse
//   rsp_rdata  slave->master  extended load data, 0 for stores/errors
//   rsp_err    slave->master  misaligned or illegal funct3
interface dmem_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data RAM with a load/store front end.
// It supports byte, half and word accesses, sign and zero extension of loads,
// misalignment and illegal-funct3 detection, and WAIT_CYCLES extra wait states
// per access.
//
// Ports:
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   bus            dmem_lsu_if slave modport (request/response)
//   dbg_state_o    current FSM state (0 idle, 1 wait, 2 resp)
//   trace_valid_o  one-cycle pulse, aligned with rsp_valid, for a committed store
//   trace_pc_o     PC of the committed store
//   trace_addr_o   word-aligned address of the committed store
//   trace_data_o   full RAM word after the byte merge
//
// Flow: IDLE accepts a request and latches it. WAIT counts down from
// WAIT_CYCLES. When the counter is 0, the WAIT->RESP edge commits the store
// and captures the load data. RESP pulses rsp_valid for one cycle and then
// returns to IDLE.
module dmem_lsu #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_lsu_if.slave         bus,
    output logic [1:0]        dbg_state_o,
    output logic              trace_valid_o,
    output logic [ADDR_W-1:0] trace_pc_o,
    output logic [ADDR_W-1:0] trace_addr_o,
    output logic [XLEN-1:0]   trace_data_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [2:0]        ctr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [ADDR_W-1:0] pc_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;
    logic              trace_valid_q;
    logic [ADDR_W-1:0] trace_pc_q;
    logic [ADDR_W-1:0] trace_addr_q;
    logic [XLEN-1:0]   trace_data_q;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [XLEN-1:0]   old_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              illegal;
    logic              misaligned;
    logic              err_d;
    logic [XLEN-1:0]   rdata_d;
    logic [XLEN-1:0]   merged_d;
    logic              commit;

    // Upper address bits are ignored, so addresses alias modulo the RAM size.
    assign idx      = addr_q[IDX_W+1:2];
    assign lane     = addr_q[1:0];
    assign old_word = mem[idx];

    always_comb begin
        illegal = 1'b0;
        if (we_q) begin
            illegal = !(funct3_q == 3'b000 || funct3_q == 3'b001 || funct3_q == 3'b010);
        end else begin
            illegal = (funct3_q == 3'b011 || funct3_q == 3'b110 || funct3_q == 3'b111);
        end
    end

    // funct3[1:0] encodes the size for every legal code (bu/hu share it with b/h).
    always_comb begin
        misaligned = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign err_d = illegal | misaligned;

    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'd0: byte_sel = old_word[7:0];
            2'd1: byte_sel = old_word[15:8];
            2'd2: byte_sel = old_word[23:16];
            2'd3: byte_sel = old_word[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    assign half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        rdata_d = '0;
        case (funct3_q)
            3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
            3'b010:  rdata_d = old_word;
            3'b100:  rdata_d = {24'h000000, byte_sel};
            3'b101:  rdata_d = {16'h0000, half_sel};
            default: rdata_d = '0;
        endcase
    end

    // Read-modify-write of the whole word, so the trace can show the merged result.
    always_comb begin
        merged_d = old_word;
        case (funct3_q[1:0])
            2'b00: begin
                case (lane)
                    2'd0: merged_d[7:0]   = wdata_q[7:0];
                    2'd1: merged_d[15:8]  = wdata_q[7:0];
                    2'd2: merged_d[23:16] = wdata_q[7:0];
                    2'd3: merged_d[31:24] = wdata_q[7:0];
                    default: merged_d = old_word;
                endcase
            end
            2'b01: begin
                if (lane[1]) merged_d[31:16] = wdata_q[15:0];
                else         merged_d[15:0]  = wdata_q[15:0];
            end
            2'b10:   merged_d = wdata_q;
            default: merged_d = old_word;
        endcase
    end

    // The async reset forces state_q to IDLE, so a store that has not reached
    // its commit edge is dropped.
    assign commit = (state_q == S_WAIT) && (ctr_q == 3'd0);

    always_ff @(posedge clk) begin
        if (commit && we_q && !err_d) begin
            mem[idx] <= merged_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            ctr_q         <= 3'd0;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            trace_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        pc_q     <= bus.req_pc;
                        ctr_q    <= 3'(WAIT_CYCLES);
                        ready_q  <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ctr_q != 3'd0) begin
                        ctr_q <= ctr_q - 3'd1;
                    end else begin
                        state_q       <= S_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= err_d;
                        rsp_rdata_q   <= (err_d || we_q) ? '0 : rdata_d;
                        trace_valid_q <= we_q && !err_d;
                        trace_pc_q    <= pc_q;
                        trace_addr_q  <= {addr_q[ADDR_W-1:2], 2'b00};
                        trace_data_q  <= merged_d;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign dbg_state_o    = state_q;
    assign trace_valid_o  = trace_valid_q;
    assign trace_pc_o     = trace_pc_q;
    assign trace_addr_o   = trace_addr_q;
    assign trace_data_o   = trace_data_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu.
// Instance A uses WAIT_CYCLES=1 and covers data, extension, error and reset
// cases. Instance B uses WAIT_CYCLES=3 and covers latency and busy-ignore.
module tb_dmem_lsu;
    logic clk;
    logic rstn_a;
    logic rstn_b;

    dmem_lsu_if #(.XLEN(32), .ADDR_W(32)) bus_a ();
    dmem_lsu_if #(.XLEN(32), .ADDR_W(32)) bus_b ();

    logic [1:0]  dbg_a, dbg_b;
    logic        tv_a, tv_b;
    logic [31:0] tpc_a, tpc_b, taddr_a, taddr_b, tdata_a, tdata_b;

    dmem_lsu #(.XLEN(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_a (
        .clk           (clk),
        .rstn          (rstn_a),
        .bus           (bus_a.slave),
        .dbg_state_o   (dbg_a),
        .trace_valid_o (tv_a),
        .trace_pc_o    (tpc_a),
        .trace_addr_o  (taddr_a),
        .trace_data_o  (tdata_a)
    );

    dmem_lsu #(.XLEN(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_b (
        .clk           (clk),
        .rstn          (rstn_b),
        .bus           (bus_b.slave),
        .dbg_state_o   (dbg_b),
        .trace_valid_o (tv_b),
        .trace_pc_o    (tpc_b),
        .trace_addr_o  (taddr_b),
        .trace_data_o  (tdata_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          pc_ctr   = 32'h1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Store trace line for every committed store on instance A.
    always @(negedge clk) begin
        if (tv_a) $display("pc = %h: dataaddr = %h, memdata = %h", tpc_a, taddr_a, tdata_a);
    end

    // ---------------- driver (instance A) ----------------
    // Issues one request and waits, with a bound, for the response.
    // exp_tv says whether a store trace is expected. When one is expected,
    // the merged word is taken from exp_q.
    task automatic lsu_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_tv,
                           output logic [31:0] rdata, output logic err);
        int lat;
        logic tv;
        logic [31:0] td;
        @(negedge clk);
        bus_a.req_valid  = 1'b1;
        bus_a.req_we     = we;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = addr;
        bus_a.req_wdata  = wdata;
        bus_a.req_pc     = pc_ctr;
        pc_ctr += 4;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        lat = 0;
        rdata = '0;
        err = 1'b0;
        tv = 1'b0;
        td = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_a.rsp_valid) begin
                rdata = bus_a.rsp_rdata;
                err   = bus_a.rsp_err;
                tv    = tv_a;
                td    = tdata_a;
                break;
            end
        end
        check({tag, "_lat"}, lat, 32'd3);
        check({tag, "_tv"}, {31'd0, tv}, {31'd0, exp_tv});
        if (tv && exp_tv && exp_q.size() != 0) check({tag, "_trace"}, td, exp_q.pop_front());
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'b000;
        bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.req_pc = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_funct3 = 3'b000;
        bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.req_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
        check("rst_rvalid", {31'd0, bus_a.rsp_valid}, 32'd0);
        check("rst_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
        check("rst_state", {30'd0, dbg_a}, 32'd0);
        @(negedge clk);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // 1: word store / load
        exp_q.push_back(32'hDEADBEEF);
        lsu_req("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, rd, er);
        check("sw100_rdata", rd, 32'h0);
        check("sw100_err", {31'd0, er}, 32'd0);
        lsu_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd, er);
        check("lw100_rdata", rd, 32'hDEADBEEF);
        check("lw100_err", {31'd0, er}, 32'd0);

        // 2: byte store and signed/unsigned byte loads
        exp_q.push_back(32'hDEADA5EF);
        lsu_req("sb101", 1'b1, 3'b000, 32'h101, 32'h000000A5, 1'b1, rd, er);
        lsu_req("lb101", 1'b0, 3'b000, 32'h101, 32'h0, 1'b0, rd, er);
        check("lb101_rdata", rd, 32'hFFFFFFA5);
        lsu_req("lbu101", 1'b0, 3'b100, 32'h101, 32'h0, 1'b0, rd, er);
        check("lbu101_rdata", rd, 32'h000000A5);

        // 3: upper-half store and half loads
        exp_q.push_back(32'h8001A5EF);
        lsu_req("sh102", 1'b1, 3'b001, 32'h102, 32'h00008001, 1'b1, rd, er);
        lsu_req("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, rd, er);
        check("lh102_rdata", rd, 32'hFFFF8001);
        lsu_req("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, rd, er);
        check("lhu102_rdata", rd, 32'h00008001);
        lsu_req("lh100", 1'b0, 3'b001, 32'h100, 32'h0, 1'b0, rd, er);
        check("lh100_rdata", rd, 32'hFFFFA5EF);
        lsu_req("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, rd, er);
        check("lb103_rdata", rd, 32'hFFFFFF80);
        lsu_req("lbu100", 1'b0, 3'b100, 32'h100, 32'h0, 1'b0, rd, er);
        check("lbu100_rdata", rd, 32'h000000EF);

        // 4: errors leave RAM untouched and give no trace
        lsu_req("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 1'b0, rd, er);
        check("lw102_err", {31'd0, er}, 32'd1);
        check("lw102_rdata", rd, 32'h0);
        lsu_req("sh101", 1'b1, 3'b001, 32'h101, 32'h0000FFFF, 1'b0, rd, er);
        check("sh101_err", {31'd0, er}, 32'd1);
        lsu_req("ld011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, rd, er);
        check("ld011_err", {31'd0, er}, 32'd1);
        check("ld011_rdata", rd, 32'h0);
        lsu_req("st100", 1'b1, 3'b100, 32'h100, 32'h11111111, 1'b0, rd, er);
        check("st100_err", {31'd0, er}, 32'd1);
        lsu_req("lw100b", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd, er);
        check("lw100b_rdata", rd, 32'h8001A5EF);
        check("lw100b_err", {31'd0, er}, 32'd0);
        // 1024 words = 4 KiB, so 0x1100 aliases 0x100
        lsu_req("lw1100", 1'b0, 3'b010, 32'h1100, 32'h0, 1'b0, rd, er);
        check("lw1100_rdata", rd, 32'h8001A5EF);

        // 6: reset during WAIT drops the pending store
        exp_q.push_back(32'hCAFEF00D);
        lsu_req("sw200", 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 1'b1, rd, er);
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_funct3 = 3'b010;
            bus_a.req_addr = 32'h200; bus_a.req_wdata = 32'h12345678; bus_a.req_pc = pc_ctr;
            @(posedge clk);
            #1;
            bus_a.req_valid = 1'b0;
            check("rst6_wait", {30'd0, dbg_a}, 32'd1);
            check("rst6_busy", {31'd0, bus_a.req_ready}, 32'd0);
            @(negedge clk);
            rstn_a = 1'b0;
            #1;
            check("rst6_idle", {30'd0, dbg_a}, 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus_a.rsp_valid || tv_a) pulses++;
            end
            rstn_a = 1'b1;
            #1;
            check("rst6_pulses", pulses, 32'd0);
            check("rst6_ready", {31'd0, bus_a.req_ready}, 32'd1);
        end
        lsu_req("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, rd, er);
        check("lw200_rdata", rd, 32'hCAFEF00D);

        // 5: WAIT_CYCLES=3 latency and busy-ignore on instance B
        begin
            int first_k, pulses, ready_bad;
            logic ready6;
            logic [31:0] td;
            first_k = 0; pulses = 0; ready_bad = 0; ready6 = 1'b0; td = '0;
            @(negedge clk);
            bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1; bus_b.req_funct3 = 3'b010;
            bus_b.req_addr = 32'h40; bus_b.req_wdata = 32'h00000055; bus_b.req_pc = 32'h2000;
            @(posedge clk);
            #1;
            // a second request held while busy must be ignored
            bus_b.req_addr = 32'h44; bus_b.req_wdata = 32'h00000066;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (bus_b.rsp_valid) begin
                    pulses++;
                    if (first_k == 0) begin
                        first_k = k;
                        td = tdata_b;
                    end
                end
                if (k <= 5 && bus_b.req_ready) ready_bad++;
                if (k == 6) ready6 = bus_b.req_ready;
                if (k == 4) bus_b.req_valid = 1'b0;
            end
            check("b_first_rsp", first_k, 32'd5);
            check("b_pulses", pulses, 32'd1);
            check("b_ready_busy", ready_bad, 32'd0);
            check("b_ready_back", {31'd0, ready6}, 32'd1);
            check("b_trace", td, 32'h00000055);
        end

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
